conv_row_scheduler: RTL and testbench
=====================================

Name: conv_row_scheduler

Overview:
Sequences one image row through the PE array and the adder_tree pipeline. Accepts a pixel stream and builds a KERNEL_SIZE-wide sliding window that feeds the PEs. Issues pe_en, then adder_en delayed to match the PE latency, and flags each adder_tree result with res_valid / res_last. Reports busy and done for the row to the top-level controller.

Parameters:
KERNEL_SIZE, 3, window width (taps per output); must match adder_tree.
DATA_WIDTH, 8, pixel width.
ROW_LEN_WIDTH, 12, width of the row length configuration.
PE_LATENCY, 1, cycles from pe_en to valid PE products at adder_dataIn.
ADDER_LATENCY, 2, cycles from adder_en to updated adder_dataOut (fixed by adder_tree: input register plus output register).

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse that starts a row
row_len  in  ROW_LEN_WIDTH  pixels in the row; sampled on start
cfg_err  out  1  one-cycle pulse when start is given with row_len < KERNEL_SIZE
busy  out  1  high from the accepted start until done
done  out  1  one-cycle pulse after the last result
pix_valid  in  1  pixel handshake valid
pix_ready  out  1  pixel handshake ready
pix_data  in  DATA_WIDTH  pixel value
win_data  out  DATA_WIDTH*KERNEL_SIZE  window to PEs; slot 0 (LSBs) holds the newest pixel
pe_en  out  1  window valid for the PEs
adder_en  out  1  drives adder_tree adder_en
res_valid  out  1  adder_tree adder_dataOut holds a new result this cycle
res_last  out  1  qualifies res_valid for the final window of the row

Behaviour:
- Reset (async, rstn=0):
  - state=IDLE.
  - All outputs 0; win_data=0.
  - All counters and delay lines cleared.
  - In-flight results are discarded. A reset mid-row abandons the row; no done pulse.
- FSM states: IDLE, FILL, RUN, DRAIN, DONE.
- IDLE:
  - pix_ready=0, busy=0.
  - start with row_len>=KERNEL_SIZE: latch row_len, clear counters, go to FILL, busy=1 from the next cycle.
  - start with row_len<KERNEL_SIZE: cfg_err=1 for one cycle; stay in IDLE.
- FILL:
  - pix_ready=1.
  - Each handshake (pix_valid&pix_ready) shifts pix_data into slot 0; older slots move up one slot; the slot K-1 value is dropped.
  - After KERNEL_SIZE-1 handshakes, go to RUN. No pe_en in FILL.
- RUN:
  - pix_ready=1.
  - Each handshake shifts the window and sets pe_en=1 in the following cycle, aligned with the updated win_data. No handshake means pe_en=0 (bubble).
  - windows_issued increments per pe_en.
  - The handshake that completes window row_len-KERNEL_SIZE+1 moves to DRAIN; pix_ready=0 from the next cycle.
- Enable delay lines:
  - adder_en = pe_en delayed by exactly PE_LATENCY cycles (shift register).
  - res_valid = adder_en delayed by exactly ADDER_LATENCY cycles.
  - res_last travels with the final window's enable through both delay lines.
  - Pixel handshake to res_valid = 1+PE_LATENCY+ADDER_LATENCY cycles (4 at default).
- DRAIN:
  - pix_ready=0.
  - Go to DONE in the cycle after res_last is asserted.
- DONE: done=1 for one cycle, busy=0 in the next cycle, return to IDLE.
- start while busy is ignored; row_len changes while busy are ignored.
- Counter widths:
  - Pixel and window counters: ROW_LEN_WIDTH bits; no wrap for row_len <= 2^ROW_LEN_WIDTH-1.
  - row_len == KERNEL_SIZE yields exactly one window.
- No result back-pressure: the adder_tree pipeline cannot stall, so the consumer must accept every res_valid.

Test Plan:
- Reset, then start with row_len=5, K=3, pixels 1..5 presented back-to-back:
  - pix_ready is high for 5 cycles.
  - pe_en fires 3 times with win_data {1,2,3}, {2,3,4}, {3,4,5} (slot0 = newest).
  - res_valid pulses 3 times, 4 cycles after pixels 3, 4 and 5; res_last on the 3rd.
  - done pulses once, then busy=0.
- Same row with pix_valid toggled 1,0,1,0,...: pe_en pulses are separated by bubbles, the window sequence is identical, and res_valid is spaced to match.
- start with row_len=2: cfg_err pulses once; busy, pix_ready and pe_en stay 0.
- row_len=3: exactly one pe_en, one res_valid with res_last=1, one done.
- start re-pulsed during RUN with row_len=7: ignored; the row still ends after the original row_len windows.
- rstn asserted low mid-RUN (after 2 of 4 windows): all outputs are 0 immediately; no res_valid or done follows. A new start after reset runs a clean row.

Source files
------------

// File: rtl/conv_row_scheduler_if.sv
// Pixel stream in, window/enable stream out, between the row scheduler and the PE/adder datapath.
// Handshake: a pixel transfers on a rising clk edge where pix_valid && pix_ready; pix_data is stable while pix_valid is high and unaccepted; results carry no ready.
interface conv_row_scheduler_if #(
  parameter int DATA_WIDTH  = 8,
  parameter int KERNEL_SIZE = 3
);
  logic                              pix_valid;
  logic                              pix_ready;
  logic [DATA_WIDTH-1:0]             pix_data;
  logic [DATA_WIDTH*KERNEL_SIZE-1:0] win_data;
  logic                              pe_en;
  logic                              adder_en;
  logic                              res_valid;
  logic                              res_last;

  modport master (
    input  pix_valid, pix_data,
    output pix_ready, win_data, pe_en, adder_en, res_valid, res_last
  );

  modport slave (
    output pix_valid, pix_data,
    input  pix_ready, win_data, pe_en, adder_en, res_valid, res_last
  );
endinterface

// File: rtl/conv_row_scheduler.sv
// Row scheduler: builds a KERNEL_SIZE sliding window from a pixel stream and times
// pe_en / adder_en / res_valid / res_last through the PE and adder_tree latencies.
module conv_row_scheduler #(
  parameter int KERNEL_SIZE   = 3,
  parameter int DATA_WIDTH    = 8,
  parameter int ROW_LEN_WIDTH = 12,
  parameter int PE_LATENCY    = 1,
  parameter int ADDER_LATENCY = 2
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     start,
  input  logic [ROW_LEN_WIDTH-1:0] row_len,
  output logic                     cfg_err,
  output logic                     busy,
  output logic                     done,
  output logic [2:0]               state_dbg,
  conv_row_scheduler_if.master     bus
);

  localparam int WW = DATA_WIDTH * KERNEL_SIZE;
  localparam logic [ROW_LEN_WIDTH-1:0] K_LEN     = ROW_LEN_WIDTH'(KERNEL_SIZE);
  localparam logic [ROW_LEN_WIDTH-1:0] FILL_LAST = ROW_LEN_WIDTH'(KERNEL_SIZE - 2);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FILL  = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t state, state_n;

  logic [ROW_LEN_WIDTH-1:0] row_len_q;
  logic [ROW_LEN_WIDTH-1:0] fill_cnt;
  logic [ROW_LEN_WIDTH-1:0] win_cnt;
  logic [WW-1:0]            win_q;
  logic                     pe_en_q;
  logic                     pe_last_q;
  logic [PE_LATENCY-1:0]    pe_dly;
  logic [PE_LATENCY-1:0]    pe_last_dly;
  logic [ADDER_LATENCY-1:0] add_dly;
  logic [ADDER_LATENCY-1:0] add_last_dly;

  logic pix_ready_w;
  logic hs;
  logic start_ok;
  logic last_win;
  logic res_last_w;

  assign pix_ready_w = (state == FILL) || (state == RUN);
  assign hs          = bus.pix_valid && pix_ready_w;
  assign start_ok    = start && (row_len >= K_LEN);
  // row_len_q >= K_LEN is guaranteed once a row is accepted, so this cannot underflow.
  assign last_win    = (win_cnt == (row_len_q - K_LEN));
  assign res_last_w  = add_last_dly[ADDER_LATENCY-1];

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_n;
  end

  // Next-state logic
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:  if (start_ok)                       state_n = FILL;
      FILL:  if (hs && (fill_cnt == FILL_LAST))  state_n = RUN;
      RUN:   if (hs && last_win)                 state_n = DRAIN;
      DRAIN: if (res_last_w)                     state_n = DONE;
      DONE:                                      state_n = IDLE;
      default:                                   state_n = IDLE;
    endcase
  end

  // Row configuration, counters and the sliding window
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cfg_err   <= 1'b0;
      row_len_q <= '0;
      fill_cnt  <= '0;
      win_cnt   <= '0;
      win_q     <= '0;
    end else begin
      cfg_err <= (state == IDLE) && start && (row_len < K_LEN);
      if ((state == IDLE) && start_ok) begin
        row_len_q <= row_len;
        fill_cnt  <= '0;
        win_cnt   <= '0;
        win_q     <= '0;
      end
      if (hs) win_q <= {win_q[WW-DATA_WIDTH-1:0], bus.pix_data};
      if (hs && (state == FILL)) fill_cnt <= fill_cnt + 1'b1;
      if (hs && (state == RUN))  win_cnt  <= win_cnt + 1'b1;
    end
  end

  // Enable pipeline; the last flag rides alongside each enable stage
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pe_en_q      <= 1'b0;
      pe_last_q    <= 1'b0;
      pe_dly       <= '0;
      pe_last_dly  <= '0;
      add_dly      <= '0;
      add_last_dly <= '0;
    end else begin
      pe_en_q   <= hs && (state == RUN);
      pe_last_q <= hs && (state == RUN) && last_win;

      pe_dly[0]      <= pe_en_q;
      pe_last_dly[0] <= pe_last_q;
      for (int i = 1; i < PE_LATENCY; i++) begin
        pe_dly[i]      <= pe_dly[i-1];
        pe_last_dly[i] <= pe_last_dly[i-1];
      end

      add_dly[0]      <= pe_dly[PE_LATENCY-1];
      add_last_dly[0] <= pe_last_dly[PE_LATENCY-1];
      for (int i = 1; i < ADDER_LATENCY; i++) begin
        add_dly[i]      <= add_dly[i-1];
        add_last_dly[i] <= add_last_dly[i-1];
      end
    end
  end

  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign state_dbg = state;

  assign bus.pix_ready = pix_ready_w;
  assign bus.win_data  = win_q;
  assign bus.pe_en     = pe_en_q;
  assign bus.adder_en  = pe_dly[PE_LATENCY-1];
  assign bus.res_valid = add_dly[ADDER_LATENCY-1];
  assign bus.res_last  = res_last_w;

endmodule

// File: tb/tb_conv_row_scheduler.sv
// Directed bench for conv_row_scheduler: event logs recorded on the falling edge,
// each scenario task compares them against hand-computed cycle offsets and windows.
module tb_conv_row_scheduler;
  localparam int K   = 3;
  localparam int DW  = 8;
  localparam int RLW = 12;
  localparam int WW  = DW * K;

  logic           clk = 1'b0;
  logic           rstn = 1'b0;
  logic           start = 1'b0;
  logic [RLW-1:0] row_len = '0;
  logic           cfg_err, busy, done;
  logic [2:0]     state_dbg;

  conv_row_scheduler_if #(.DATA_WIDTH(DW), .KERNEL_SIZE(K)) bus ();

  conv_row_scheduler #(
    .KERNEL_SIZE(K), .DATA_WIDTH(DW), .ROW_LEN_WIDTH(RLW),
    .PE_LATENCY(1), .ADDER_LATENCY(2)
  ) dut (
    .clk(clk), .rstn(rstn), .start(start), .row_len(row_len),
    .cfg_err(cfg_err), .busy(busy), .done(done), .state_dbg(state_dbg),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Clock/cycle counter and event logs
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int fails  = 0;
  logic [WW-1:0] exp_q[$];
  int hs_cyc[$], pe_cyc[$], res_cyc[$], last_cyc[$], done_cyc[$], cfg_cyc[$];
  logic [WW-1:0] pe_win[$];
  int ready_n = 0;
  int busy_n  = 0;

  always @(negedge clk) begin
    if (bus.pix_valid && bus.pix_ready) hs_cyc.push_back(cyc);
    if (bus.pe_en) begin
      pe_cyc.push_back(cyc);
      pe_win.push_back(bus.win_data);
    end
    if (bus.res_valid) res_cyc.push_back(cyc);
    if (bus.res_valid && bus.res_last) last_cyc.push_back(cyc);
    if (done) done_cyc.push_back(cyc);
    if (cfg_err) cfg_cyc.push_back(cyc);
    if (bus.pix_ready) ready_n <= ready_n + 1;
    if (busy) busy_n <= busy_n + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic pulse_start(input int len, output int s);
    row_len = RLW'(len);
    start   = 1'b1;
    s       = cyc;
    step();
    start   = 1'b0;
  endtask

  task automatic send_pixels(input int n, input bit gaps);
    int idx;
    int guard;
    bit hs;
    idx = 0;
    guard = 0;
    while (idx < n && guard < 100) begin
      bus.pix_valid = gaps ? (guard % 2 == 0) : 1'b1;
      bus.pix_data  = DW'(idx + 1);
      @(negedge clk);
      hs = bus.pix_valid && bus.pix_ready;
      step();
      if (hs) idx++;
      guard++;
    end
    bus.pix_valid = 1'b0;
    bus.pix_data  = '0;
  endtask

  // Scenarios
  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (bus.pix_ready !== 1'b0) begin fails++; $display("FAIL reset_pix_ready: got %b expected 0", bus.pix_ready); end
    checks++; if (bus.pe_en !== 1'b0) begin fails++; $display("FAIL reset_pe_en: got %b expected 0", bus.pe_en); end
    checks++; if (bus.win_data !== '0) begin fails++; $display("FAIL reset_win_data: got %h expected 0", bus.win_data); end
    checks++; if (state_dbg !== 3'd0) begin fails++; $display("FAIL reset_state: got %0d expected 0", state_dbg); end
    checks++; if ({done, cfg_err, bus.res_valid, bus.adder_en} !== 4'b0) begin fails++; $display("FAIL reset_pulses: got %b expected 0000", {done, cfg_err, bus.res_valid, bus.adder_en}); end
    rstn = 1'b1;
    step();
    step();
  endtask

  task automatic test_back_to_back();
    int s, got, b_pe, b_res, b_last, b_done, r0, u0;
    logic [WW-1:0] e, w;
    b_pe = pe_cyc.size(); b_res = res_cyc.size(); b_last = last_cyc.size();
    b_done = done_cyc.size(); r0 = ready_n; u0 = busy_n;
    pulse_start(5, s);
    send_pixels(5, 1'b0);
    repeat (12) step();
    checks++; if (ready_n - r0 !== 5) begin fails++; $display("FAIL b2b_ready_cycles: got %0d expected 5", ready_n - r0); end
    checks++; if (pe_cyc.size() - b_pe !== 3) begin fails++; $display("FAIL b2b_pe_count: got %0d expected 3", pe_cyc.size() - b_pe); end
    for (int i = 0; i < 3; i++) begin
      got = (b_pe + i < pe_cyc.size()) ? pe_cyc[b_pe + i] : -1;
      checks++; if (got !== s + 4 + i) begin fails++; $display("FAIL b2b_pe_cycle[%0d]: got %0d expected %0d", i, got, s + 4 + i); end
      got = (b_res + i < res_cyc.size()) ? res_cyc[b_res + i] : -1;
      checks++; if (got !== s + 7 + i) begin fails++; $display("FAIL b2b_res_cycle[%0d]: got %0d expected %0d", i, got, s + 7 + i); end
    end
    exp_q.push_back(24'h010203);
    exp_q.push_back(24'h020304);
    exp_q.push_back(24'h030405);
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      w = (b_pe + i < pe_win.size()) ? pe_win[b_pe + i] : 'x;
      checks++; if (w !== e) begin fails++; $display("FAIL b2b_window[%0d]: got %h expected %h", i, w, e); end
    end
    checks++; if (res_cyc.size() - b_res !== 3) begin fails++; $display("FAIL b2b_res_count: got %0d expected 3", res_cyc.size() - b_res); end
    got = (last_cyc.size() > b_last) ? last_cyc[b_last] : -1;
    checks++; if (got !== s + 9 || last_cyc.size() - b_last !== 1) begin fails++; $display("FAIL b2b_res_last: got cycle %0d count %0d expected cycle %0d count 1", got, last_cyc.size() - b_last, s + 9); end
    got = (done_cyc.size() > b_done) ? done_cyc[b_done] : -1;
    checks++; if (got !== s + 10 || done_cyc.size() - b_done !== 1) begin fails++; $display("FAIL b2b_done: got cycle %0d count %0d expected cycle %0d count 1", got, done_cyc.size() - b_done, s + 10); end
    checks++; if (busy_n - u0 !== 10) begin fails++; $display("FAIL b2b_busy_cycles: got %0d expected 10", busy_n - u0); end
  endtask

  task automatic test_bubbles();
    int s, got, b_pe, b_res, b_done, r0;
    logic [WW-1:0] e, w;
    b_pe = pe_cyc.size(); b_res = res_cyc.size(); b_done = done_cyc.size(); r0 = ready_n;
    pulse_start(5, s);
    send_pixels(5, 1'b1);
    repeat (12) step();
    checks++; if (pe_cyc.size() - b_pe !== 3) begin fails++; $display("FAIL bub_pe_count: got %0d expected 3", pe_cyc.size() - b_pe); end
    for (int i = 0; i < 3; i++) begin
      got = (b_pe + i < pe_cyc.size()) ? pe_cyc[b_pe + i] : -1;
      checks++; if (got !== s + 6 + 2 * i) begin fails++; $display("FAIL bub_pe_cycle[%0d]: got %0d expected %0d", i, got, s + 6 + 2 * i); end
      got = (b_res + i < res_cyc.size()) ? res_cyc[b_res + i] : -1;
      checks++; if (got !== s + 9 + 2 * i) begin fails++; $display("FAIL bub_res_cycle[%0d]: got %0d expected %0d", i, got, s + 9 + 2 * i); end
    end
    exp_q.push_back(24'h010203);
    exp_q.push_back(24'h020304);
    exp_q.push_back(24'h030405);
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      w = (b_pe + i < pe_win.size()) ? pe_win[b_pe + i] : 'x;
      checks++; if (w !== e) begin fails++; $display("FAIL bub_window[%0d]: got %h expected %h", i, w, e); end
    end
    got = (done_cyc.size() > b_done) ? done_cyc[b_done] : -1;
    checks++; if (got !== s + 14) begin fails++; $display("FAIL bub_done: got %0d expected %0d", got, s + 14); end
    checks++; if (ready_n - r0 !== 9) begin fails++; $display("FAIL bub_ready_cycles: got %0d expected 9", ready_n - r0); end
  endtask

  task automatic test_cfg_err();
    int s, got, b_cfg, b_pe, r0, u0;
    b_cfg = cfg_cyc.size(); b_pe = pe_cyc.size(); r0 = ready_n; u0 = busy_n;
    pulse_start(2, s);
    repeat (6) step();
    got = (cfg_cyc.size() > b_cfg) ? cfg_cyc[b_cfg] : -1;
    checks++; if (got !== s + 1 || cfg_cyc.size() - b_cfg !== 1) begin fails++; $display("FAIL cfg_err_pulse: got cycle %0d count %0d expected cycle %0d count 1", got, cfg_cyc.size() - b_cfg, s + 1); end
    checks++; if (busy_n - u0 !== 0) begin fails++; $display("FAIL cfg_busy: got %0d expected 0", busy_n - u0); end
    checks++; if (ready_n - r0 !== 0) begin fails++; $display("FAIL cfg_ready: got %0d expected 0", ready_n - r0); end
    checks++; if (pe_cyc.size() - b_pe !== 0) begin fails++; $display("FAIL cfg_pe: got %0d expected 0", pe_cyc.size() - b_pe); end
  endtask

  task automatic test_min_row();
    int s, got, b_pe, b_res, b_last, b_done;
    b_pe = pe_cyc.size(); b_res = res_cyc.size(); b_last = last_cyc.size(); b_done = done_cyc.size();
    pulse_start(3, s);
    send_pixels(3, 1'b0);
    repeat (10) step();
    checks++; if (pe_cyc.size() - b_pe !== 1) begin fails++; $display("FAIL min_pe_count: got %0d expected 1", pe_cyc.size() - b_pe); end
    checks++; if (res_cyc.size() - b_res !== 1) begin fails++; $display("FAIL min_res_count: got %0d expected 1", res_cyc.size() - b_res); end
    got = (last_cyc.size() > b_last) ? last_cyc[b_last] : -1;
    checks++; if (got !== s + 7) begin fails++; $display("FAIL min_res_last: got %0d expected %0d", got, s + 7); end
    got = (done_cyc.size() > b_done) ? done_cyc[b_done] : -1;
    checks++; if (got !== s + 8 || done_cyc.size() - b_done !== 1) begin fails++; $display("FAIL min_done: got cycle %0d count %0d expected cycle %0d count 1", got, done_cyc.size() - b_done, s + 8); end
  endtask

  task automatic test_restart_ignored();
    int s, got, b_pe, b_last, b_done, b_cfg, u0;
    b_pe = pe_cyc.size(); b_last = last_cyc.size(); b_done = done_cyc.size();
    b_cfg = cfg_cyc.size(); u0 = busy_n;
    pulse_start(5, s);
    fork
      send_pixels(5, 1'b0);
      begin
        repeat (3) step();
        start   = 1'b1;
        row_len = RLW'(7);
        step();
        start   = 1'b0;
      end
    join
    repeat (12) step();
    checks++; if (pe_cyc.size() - b_pe !== 3) begin fails++; $display("FAIL rst_ign_pe_count: got %0d expected 3", pe_cyc.size() - b_pe); end
    got = (last_cyc.size() > b_last) ? last_cyc[b_last] : -1;
    checks++; if (got !== s + 9) begin fails++; $display("FAIL rst_ign_res_last: got %0d expected %0d", got, s + 9); end
    got = (done_cyc.size() > b_done) ? done_cyc[b_done] : -1;
    checks++; if (got !== s + 10 || done_cyc.size() - b_done !== 1) begin fails++; $display("FAIL rst_ign_done: got cycle %0d count %0d expected cycle %0d count 1", got, done_cyc.size() - b_done, s + 10); end
    checks++; if (busy_n - u0 !== 10 || cfg_cyc.size() - b_cfg !== 0) begin fails++; $display("FAIL rst_ign_busy: got busy %0d cfg_err %0d expected busy 10 cfg_err 0", busy_n - u0, cfg_cyc.size() - b_cfg); end
  endtask

  task automatic test_reset_mid_row();
    int s, k, got, b_pe, b_res, b_done;
    bit hit;
    logic [WW-1:0] w;
    b_pe = pe_cyc.size(); b_res = res_cyc.size(); b_done = done_cyc.size();
    pulse_start(6, s);
    k = 1;
    hit = 1'b0;
    while (k <= 12 && !hit) begin
      bus.pix_valid = 1'b1;
      bus.pix_data  = DW'(k);
      @(negedge clk); #1;
      if (pe_cyc.size() - b_pe >= 2) hit = 1'b1;
      else begin
        step();
        k++;
      end
    end
    checks++; if (hit !== 1'b1 || cyc !== s + 5) begin fails++; $display("FAIL mid_two_windows: got hit %0d cycle %0d expected hit 1 cycle %0d", hit, cyc, s + 5); end
    rstn = 1'b0;
    bus.pix_valid = 1'b0;
    #1;
    checks++; if ({busy, bus.pix_ready, bus.pe_en, bus.adder_en} !== 4'b0) begin fails++; $display("FAIL mid_reset_outputs: got %b expected 0000", {busy, bus.pix_ready, bus.pe_en, bus.adder_en}); end
    checks++; if ({bus.res_valid, bus.res_last, done, cfg_err} !== 4'b0 || bus.win_data !== '0 || state_dbg !== 3'd0) begin fails++; $display("FAIL mid_reset_state: got pulses %b win %h state %0d expected 0", {bus.res_valid, bus.res_last, done, cfg_err}, bus.win_data, state_dbg); end
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    step();
    repeat (10) step();
    checks++; if (res_cyc.size() - b_res !== 0 || done_cyc.size() - b_done !== 0) begin fails++; $display("FAIL mid_abandoned: got res %0d done %0d expected 0 0", res_cyc.size() - b_res, done_cyc.size() - b_done); end
    b_pe = pe_cyc.size(); b_done = done_cyc.size();
    pulse_start(3, s);
    send_pixels(3, 1'b0);
    repeat (10) step();
    w = (pe_win.size() > b_pe) ? pe_win[b_pe] : 'x;
    exp_q.push_back(24'h010203);
    checks++; if (w !== exp_q[0] || pe_cyc.size() - b_pe !== 1) begin fails++; $display("FAIL mid_clean_window: got %h count %0d expected %h count 1", w, pe_cyc.size() - b_pe, exp_q[0]); end
    void'(exp_q.pop_front());
    got = (done_cyc.size() > b_done) ? done_cyc[b_done] : -1;
    checks++; if (got !== s + 8) begin fails++; $display("FAIL mid_clean_done: got %0d expected %0d", got, s + 8); end
  endtask

  initial begin
    bus.pix_valid = 1'b0;
    bus.pix_data  = '0;
    test_reset();
    test_back_to_back();
    test_bubbles();
    test_cfg_err();
    test_min_row();
    test_restart_ignored();
    test_reset_mid_row();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
